xmem_streamer: RTL and testbench

XMEM_STREAMER -- requirements
Module: xmem_streamer

---
 rtl/xmem_pkg.sv | 18 +
 rtl/xmem_streamer_pair_fifo2.sv | 67 ++++++
 rtl/xmem_streamer.sv | 131 +++++++++++++
 tb/tb_xmem_streamer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xmem_pkg.sv
// Shared definitions for the memory-side blocks.
//   XMEM_ADDR_W / XMEM_DATA_W / XMEM_CNT_W : default word address, word and
//                                            pair-count widths
//   state_t                                : streamer control state encoding
package xmem_pkg;

  localparam int XMEM_ADDR_W = 11;
  localparam int XMEM_DATA_W = 32;
  localparam int XMEM_CNT_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/xmem_streamer_pair_fifo2.sv
// pair_fifo2: two-entry FIFO holding (even, odd) word pairs.
//   clk, rst_n           : clock, asynchronous active-low reset
//   push, push_data0/1   : write one pair
//   pop                  : remove the head pair
//   valid                : FIFO not empty
//   data0, data1         : head pair (reads 0 after reset)
//   count                : number of stored pairs, 0..2
module pair_fifo2
  import xmem_pkg::*;
#(
  parameter int DATA_W = XMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data0,
  input  logic [DATA_W-1:0] push_data1,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem0 [2];
  logic [DATA_W-1:0] mem1 [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              pop_ok;
  logic              push_ok;

  // Guard against misuse so a full FIFO is never overwritten and an empty
  // one never underflows.
  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem0[wr_ptr] <= push_data0;
        mem1[wr_ptr] <= push_data1;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign data0 = mem0[rd_ptr];
  assign data1 = mem1[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/xmem_streamer.sv
// xmem_streamer: streams num_pairs word pairs starting at base_addr out of a
// dual-port synchronous-read memory (even word on port 0, odd word on port 1).
//   CLK, RESET_N              : clock, asynchronous active-low reset
//   start, base_addr, num_pairs : stream request, sampled only in IDLE
//   busy, done                : stream in progress / one-cycle completion pulse
//   CEN0/1, WEN0/1, A0/1, Q0/1 : memory ports (read-only use)
//   out_valid, out_ready, out_data0/1, out_last : output pair stream
//   dbg_state                 : current control state
//
// Output handshake: a pair transfers on a rising edge where out_valid and
// out_ready are both high; once out_valid rises, out_data0/1 and out_last
// stay unchanged until that transfer happens.
module xmem_streamer
  import xmem_pkg::*;
#(
  parameter int ADDR_W = XMEM_ADDR_W,
  parameter int DATA_W = XMEM_DATA_W,
  parameter int CNT_W  = XMEM_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_pairs,
  output logic              busy,
  output logic              done,
  output logic              CEN0,
  output logic              CEN1,
  output logic              WEN0,
  output logic              WEN1,
  output logic [ADDR_W-1:0] A0,
  output logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] Q0,
  input  logic [DATA_W-1:0] Q1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic              out_last,
  output state_t            dbg_state
);

  state_t            state;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W-1:0] nxt_addr1;
  logic [ADDR_W-1:0] a0_last;
  logic [ADDR_W-1:0] a1_last;
  logic [CNT_W-1:0]  issue_left;
  logic [CNT_W-1:0]  xfer_left;
  logic              rd_inflight;   // read data is on Q0/Q1 this cycle
  logic              issue;
  logic              pop;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [2:0]        credit;

  assign pop       = fifo_valid && out_ready;
  assign nxt_addr1 = nxt_addr + ADDR_W'(1);

  // Pairs already claiming a FIFO slot: stored ones plus the one on the
  // memory outputs, less the one leaving this cycle. Issue is combinational
  // so a read costs one cycle less latency, which is what lets a 2-entry
  // FIFO sustain one pair per cycle without ever overflowing.
  assign credit = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, pop};
  assign issue  = (state == ST_RUN) && (credit < 3'd2);

  assign CEN0 = ~issue;
  assign CEN1 = ~issue;
  assign WEN0 = 1'b1;
  assign WEN1 = 1'b1;
  // Addresses show the live request while issuing, else the last one used.
  assign A0   = issue ? nxt_addr  : a0_last;
  assign A1   = issue ? nxt_addr1 : a1_last;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      nxt_addr    <= '0;
      a0_last     <= '0;
      a1_last     <= '0;
      issue_left  <= '0;
      xfer_left   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= issue;
      if (issue) begin
        a0_last    <= nxt_addr;
        a1_last    <= nxt_addr1;
        nxt_addr   <= nxt_addr + ADDR_W'(2);
        issue_left <= issue_left - CNT_W'(1);
      end
      if (pop) xfer_left <= xfer_left - CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            nxt_addr   <= base_addr;
            issue_left <= num_pairs;
            xfer_left  <= num_pairs;
            state      <= (num_pairs == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN:   if (issue && (issue_left == CNT_W'(1))) state <= ST_DRAIN;
        ST_DRAIN: if (pop && (xfer_left == CNT_W'(1)))    state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  pair_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .push       (rd_inflight),
    .push_data0 (Q0),
    .push_data1 (Q1),
    .pop        (pop),
    .valid      (fifo_valid),
    .data0      (out_data0),
    .data1      (out_data1),
    .count      (fifo_count)
  );

  assign out_valid = fifo_valid;
  // The head pair is the final one exactly when one transfer remains.
  assign out_last  = fifo_valid && (xfer_left == CNT_W'(1));

endmodule

// File: tb/tb_xmem_streamer.sv
// Testbench for xmem_streamer: memory model holding word k = k at address k,
// table-driven streams, randomized streams, and a mid-stream reset sequence.
module tb_xmem_streamer;
  import xmem_pkg::*;

  localparam int EW = 65;  // {last, data0, data1}

  logic        CLK;
  logic        RESET_N;
  logic        start;
  logic [10:0] base_addr;
  logic [9:0]  num_pairs;
  logic        busy, done;
  logic        CEN0, CEN1, WEN0, WEN1;
  logic [10:0] A0, A1;
  logic [31:0] Q0, Q1;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data0, out_data1;
  state_t      dbg_state;

  xmem_streamer dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .base_addr(base_addr),
    .num_pairs(num_pairs), .busy(busy), .done(done), .CEN0(CEN0), .CEN1(CEN1),
    .WEN0(WEN0), .WEN1(WEN1), .A0(A0), .A1(A1), .Q0(Q0), .Q1(Q1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data0(out_data0),
    .out_data1(out_data1), .out_last(out_last), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int gcyc = 0;
  always @(posedge CLK) gcyc <= gcyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [2048];
  initial for (int k = 0; k < 2048; k++) mem[k] = 32'(k);
  always @(posedge CLK) begin
    if (!CEN0) Q0 <= mem[A0];
    if (!CEN1) Q1 <= mem[A1];
  end

  // ---------------- check bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // The stimulus side only publishes a stream descriptor; the scoreboard
  // derives expected pairs and addresses from it with plain arithmetic.
  logic        mon_en = 1'b0;
  int          s_id = 0;
  logic [10:0] s_base = '0;
  logic [9:0]  s_n = '0;

  int          seen_id = 0;
  logic [EW-1:0] exp_q[$];
  logic [10:0] addr_q[$];
  int          issued = 0, xferred = 0, stream_xfers = 0, last_xfer_g = 0;

  always @(negedge CLK) begin : scoreboard
    logic [10:0]   a0, a1, ea;
    logic [EW-1:0] head;
    logic          xfer;
    if (s_id != seen_id) begin
      seen_id = s_id;
      exp_q.delete();
      addr_q.delete();
      issued = 0; xferred = 0; stream_xfers = 0;
      for (int i = 0; i < int'(s_n); i++) begin
        a0 = s_base + 11'(2 * i);
        a1 = a0 + 11'd1;
        exp_q.push_back({(i == int'(s_n) - 1), 32'(a0), 32'(a1)});
        addr_q.push_back(a0);
      end
    end
    if (mon_en) begin
      xfer = out_valid && out_ready;
      check("wen0_high", WEN0, 1);
      check("wen1_high", WEN1, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) check("no_valid_expected", out_valid, 0);
        else begin
          head = exp_q[0];
          check("out_data0", out_data0, head[63:32]);
          check("out_data1", out_data1, head[31:0]);
          check("out_last", out_last, head[64]);
        end
      end else begin
        check("out_last_idle", out_last, 0);
      end
      if (!CEN0 || !CEN1) begin
        check("cen0_low", CEN0, 0);
        check("cen1_low", CEN1, 0);
        if (addr_q.size() == 0) check("no_issue_expected", CEN0, 1);
        else begin
          ea = addr_q.pop_front();
          check("addr0", A0, ea);
          check("addr1", A1, ea + 11'd1);
        end
        // outstanding reads (issued, not yet handed off) after this cycle's transfer
        check("issue_credit", ((issued - xferred - int'(xfer)) < 2), 1);
        issued++;
      end
      if (xfer) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        xferred++;
        stream_xfers++;
        last_xfer_g = gcyc;
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic ready_fn(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return c[0];
      2:       return (c >= 6 && c <= 10) ? 1'b0 : c[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_stream(input logic [10:0] base, input logic [9:0] n, input int rmode,
                            input int pulse_at, input int exp_lat, input int exp_done);
    int cyc, first_valid, first_g, done_cyc, done_g;
    s_base = base; s_n = n; s_id++;
    start = 1'b1; base_addr = base; num_pairs = n; out_ready = 1'b0;
    @(posedge CLK); #1;            // start accepted on this edge
    cyc = 1; first_valid = -1; first_g = 0; done_cyc = -1; done_g = 0;
    while (cyc < 400 && done_cyc < 0) begin
      out_ready = ready_fn(rmode, cyc);
      start     = (cyc == pulse_at);
      base_addr = 11'($urandom_range(0, 2047));
      num_pairs = 10'($urandom_range(0, 1023));
      @(negedge CLK);
      check("busy_in_stream", busy, 1);
      if (out_valid && first_valid < 0) begin first_valid = cyc; first_g = gcyc; end
      if (done) begin done_cyc = cyc; done_g = gcyc; end
      @(posedge CLK); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", (done_cyc >= 0), 1);
    if (n == 0) check("no_valid_for_zero", first_valid, -1);
    else        check("first_valid_latency", first_valid, exp_lat);
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    if (n > 0 && done_cyc >= 0) check("done_after_last", done_g - last_xfer_g, 1);
    check("xfer_count", stream_xfers, n);
    if (rmode == 0 && n > 0) check("throughput", last_xfer_g - first_g, int'(n) - 1);
    @(negedge CLK);
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
    @(posedge CLK); #1;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_cen0"}, CEN0, 1);
    check({tag, "_cen1"}, CEN1, 1);
    check({tag, "_wen0"}, WEN0, 1);
    check({tag, "_wen1"}, WEN1, 1);
    check({tag, "_a0"}, A0, 0);
    check({tag, "_a1"}, A1, 0);
    check({tag, "_d0"}, out_data0, 0);
    check({tag, "_d1"}, out_data1, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [10:0] base;
    logic [9:0]  n;
    int          rmode;     // 0 ready high, 1 toggle, 2 toggle + 5-cycle stall, 3 random
    int          pulse_at;  // cycle of an extra start pulse, -1 none
    int          exp_lat;   // cycles from accepting edge to first out_valid
    int          exp_done;  // cycle of the done pulse, -1 unchecked
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int cyc;
    vecs[0] = '{base: 11'd0,    n: 10'd4, rmode: 0, pulse_at: -1, exp_lat: 3, exp_done: 7};
    vecs[1] = '{base: 11'd2046, n: 10'd2, rmode: 0, pulse_at: -1, exp_lat: 3, exp_done: 5};
    vecs[2] = '{base: 11'd0,    n: 10'd8, rmode: 2, pulse_at: -1, exp_lat: 3, exp_done: -1};
    vecs[3] = '{base: 11'd100,  n: 10'd0, rmode: 0, pulse_at: -1, exp_lat: 3, exp_done: 1};
    vecs[4] = '{base: 11'd20,   n: 10'd6, rmode: 0, pulse_at: 3,  exp_lat: 3, exp_done: 9};
    vecs[5] = '{base: 11'd2040, n: 10'd5, rmode: 1, pulse_at: -1, exp_lat: 3, exp_done: -1};

    RESET_N = 1'b0; start = 1'b0; base_addr = '0; num_pairs = '0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_rst("por");
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    mon_en = 1'b1;

    for (int v = 0; v < 6; v++)
      run_stream(vecs[v].base, vecs[v].n, vecs[v].rmode, vecs[v].pulse_at,
                 vecs[v].exp_lat, vecs[v].exp_done);

    for (int r = 0; r < 20; r++)
      run_stream(11'($urandom_range(0, 2047)), 10'($urandom_range(0, 12)), 3, -1, 3, -1);

    // Reset in the middle of an 8-pair stream, after 3 transfers.
    s_base = 11'd0; s_n = 10'd8; s_id++;
    start = 1'b1; base_addr = 11'd0; num_pairs = 10'd8; out_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 0;
    while (stream_xfers < 3 && cyc < 50) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check("mid_xfers_reached", stream_xfers, 3);
    RESET_N = 1'b0;
    mon_en  = 1'b0;
    #1;
    check_rst("mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("rst_hold_done", done, 0);
      check("rst_hold_busy", busy, 0);
    end
    s_n = 10'd0; s_id++;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    mon_en = 1'b1;
    run_stream(11'd10, 10'd1, 0, -1, 3, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
